frame_reader_vga: RTL and testbench

FRAME_READER_VGA -- requirements
Module: frame_reader_vga

---
 rtl/frame_reader_vga.sv | 120 ++++++++++++
 tb/tb_frame_reader_vga.sv | 131 +++++++++++++
 2 files changed

// File: rtl/frame_reader_vga.sv
// VGA timing generator that scans a half-resolution frame buffer and doubles each source pixel 2x2.
// Counter stage -> read stage (address/strobe) -> output stage (syncs, de, gated colour); 2 clocks to the pins.
module frame_reader_vga #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned SRC_W    = 320
) (
  input  logic        pclk,
  input  logic        reset,
  output logic [16:0] rd_addr,
  output logic        rd_en,
  input  logic [11:0] rd_data,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned AW      = 17;

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic [AW-1:0] row_base;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          hsync_on;
  logic          vsync_on;
  logic          first_px;

  // Pipeline stage 1 companions of rd_en/rd_addr (sync flags kept active-high)
  logic          de_1;
  logic          hs_on_1;
  logic          vs_on_1;
  logic          fs_1;

  assign h_last   = (hcnt == HW'(H_TOTAL - 1));
  assign v_last   = (vcnt == VW'(V_TOTAL - 1));
  assign active   = (hcnt < HW'(H_ACTIVE)) && (vcnt < VW'(V_ACTIVE));
  assign hsync_on = (hcnt >= HW'(H_ACTIVE + H_FP)) && (hcnt < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vsync_on = (vcnt >= VW'(V_ACTIVE + V_FP)) && (vcnt < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign first_px = (hcnt == '0) && (vcnt == '0);

  // Raster counters and the source row base; the base steps once per pair of lines
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hcnt     <= '0;
      vcnt     <= '0;
      row_base <= '0;
    end else if (h_last) begin
      hcnt <= '0;
      if (v_last) begin
        vcnt     <= '0;
        row_base <= '0;
      end else begin
        vcnt <= vcnt + VW'(1);
        if (vcnt[0] && (vcnt < VW'(V_ACTIVE))) begin
          row_base <= row_base + AW'(SRC_W);
        end
      end
    end else begin
      hcnt <= hcnt + HW'(1);
    end
  end

  // Read stage: address holds its last value through blanking
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      de_1    <= 1'b0;
      hs_on_1 <= 1'b0;
      vs_on_1 <= 1'b0;
      fs_1    <= 1'b0;
    end else begin
      rd_en   <= active;
      if (active) begin
        rd_addr <= row_base + AW'(hcnt[HW-1:1]);
      end
      de_1    <= active;
      hs_on_1 <= hsync_on;
      vs_on_1 <= vsync_on;
      fs_1    <= first_px;
    end
  end

  // Output stage: aligned with the RAM's registered read data
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      vga_de      <= 1'b0;
      vga_hsync   <= 1'b1;
      vga_vsync   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vga_de      <= de_1;
      vga_hsync   <= ~hs_on_1;
      vga_vsync   <= ~vs_on_1;
      frame_start <= fs_1;
    end
  end

  // rd_data is already a registered RAM output; only blanking gating is applied here
  assign vga_r = vga_de ? rd_data[11:8] : 4'd0;
  assign vga_g = vga_de ? rd_data[7:4]  : 4'd0;
  assign vga_b = vga_de ? rd_data[3:0]  : 4'd0;

endmodule

// File: tb/tb_frame_reader_vga.sv
// Bench for frame_reader_vga on a reduced raster, checked against a position-based reference model
// with randomly timed asynchronous resets.
module tb_frame_reader_vga;

  localparam int unsigned HA = 8, HFP = 2, HS = 2, HBP = 2;
  localparam int unsigned VA = 4, VFP = 1, VS = 1, VBP = 1;
  localparam int unsigned SW = 4;
  localparam int unsigned HT = HA + HFP + HS + HBP;
  localparam int unsigned VT = VA + VFP + VS + VBP;
  localparam int unsigned FRAME = HT * VT;
  localparam int unsigned ADDR_MAX = (VA / 2 - 1) * SW + HA / 2 - 1;

  logic        pclk = 1'b0;
  logic        reset;
  logic [16:0] rd_addr;
  logic        rd_en;
  logic [11:0] rd_data = '0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hsync, vga_vsync, vga_de, frame_start;

  int unsigned n_pass = 0;
  int unsigned n_checks = 0;
  int unsigned t = 0;
  int unsigned exp_addr = 0;

  frame_reader_vga #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .SRC_W(SW)
  ) dut (
    .pclk(pclk), .reset(reset),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
    .vga_de(vga_de), .frame_start(frame_start)
  );

  always #5 pclk = ~pclk;

  // Synchronous RAM whose content equals the low 12 address bits
  always @(posedge pclk) rd_data <= rd_addr[11:0];

  // Clock edges since the last reset release
  always @(posedge pclk or posedge reset) begin
    if (reset) t <= 0;
    else       t <= t + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0d, time %0t)", tag, got, exp, t, $time);
  endtask

  function automatic logic is_active(input int unsigned q);
    return ((q % HT) < HA) && ((q / HT) < VA);
  endfunction

  function automatic int unsigned addr_of(input int unsigned q);
    return ((q / HT) / 2) * SW + (q % HT) / 2;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_de"}, vga_de, 0);
    check({tag, "_hsync"}, vga_hsync, 1);
    check({tag, "_vsync"}, vga_vsync, 1);
    check({tag, "_fs"}, frame_start, 0);
    check({tag, "_rgb"}, {vga_r, vga_g, vga_b}, 0);
  endtask

  // Output at edge count t reflects raster position t-1 (read stage) and t-2 (pins)
  task automatic compare_cycle();
    int unsigned q, x, y;
    logic exp_en, exp_de, exp_hs, exp_vs, exp_fs;
    logic [11:0] exp_px;
    if (reset) begin
      check_reset_values("rst");
      exp_addr = 0;
      return;
    end
    exp_en = 1'b0;
    if (t >= 1) begin
      q = (t - 1) % FRAME;
      exp_en = is_active(q);
      if (exp_en) exp_addr = addr_of(q);
    end
    check("rd_en", rd_en, exp_en);
    check("rd_addr", rd_addr, exp_addr);
    check("addr_max", rd_addr <= ADDR_MAX, 1);
    exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_fs = 1'b0; exp_px = '0;
    if (t >= 2) begin
      q = (t - 2) % FRAME;
      x = q % HT;
      y = q / HT;
      exp_de = is_active(q);
      exp_hs = !((x >= HA + HFP) && (x < HA + HFP + HS));
      exp_vs = !((y >= VA + VFP) && (y < VA + VFP + VS));
      exp_fs = (q == 0);
      if (exp_de) exp_px = 12'(addr_of(q));
    end
    check("vga_de", vga_de, exp_de);
    check("hsync", vga_hsync, exp_hs);
    check("vsync", vga_vsync, exp_vs);
    check("frame_start", frame_start, exp_fs);
    check("rgb", {vga_r, vga_g, vga_b}, exp_px);
  endtask

  initial begin
    int unsigned run;
    reset = 1'b1;
    #1 check_reset_values("por");
    repeat (3) begin @(negedge pclk); compare_cycle(); end
    #2 reset = 1'b0;
    for (int seg = 0; seg < 6; seg++) begin
      run = (seg == 0) ? 3 * FRAME : $urandom_range(5, 2 * FRAME);
      repeat (run) begin @(negedge pclk); compare_cycle(); end
      @(posedge pclk);
      #($urandom_range(1, 3));
      reset = 1'b1;
      #1 check_reset_values("async");
      repeat ($urandom_range(1, 4)) begin @(negedge pclk); compare_cycle(); end
      #2 reset = 1'b0;
    end
    repeat (2 * FRAME + 5) begin @(negedge pclk); compare_cycle(); end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
